// File: rtl/rotary_commit_if.sv
// rotary_commit_if: groups the input-side and video-side signals of the
// frame-synchronous commit stage.
//   counter_i  position from the rotary counter (W bits)
//   vs_i       vertical sync level, active-high
//   value_o    committed setting (W bits)
//   changed_o  one-cycle strobe when value_o takes a new value
//   osd_o      on-screen-display enable
// The master modport is the stimulus/input side, the slave modport is the
// commit stage itself.
interface rotary_commit_if #(
    parameter int W = 4
) ();
    logic [W-1:0] counter_i;
    logic         vs_i;
    logic [W-1:0] value_o;
    logic         changed_o;
    logic         osd_o;

    modport master (
        output counter_i,
        output vs_i,
        input  value_o,
        input  changed_o,
        input  osd_o
    );

    modport slave (
        input  counter_i,
        input  vs_i,
        output value_o,
        output changed_o,
        output osd_o
    );
endinterface

// File: rtl/rotary_commit.sv
// rotary_commit: takes the free-running rotary position, waits until it has
// been constant for SETTLE cycles, and applies it to value_o only on the
// next vertical-sync rising edge so a setting never changes mid-frame.
// A one-cycle changed_o strobe marks each commit and osd_o stays high for
// HOLD_FRAMES frames after the latest commit.
// Ports:
//   clk_i  the only clock
//   rst_i  synchronous, active-high reset
//   bus    rotary_commit_if.slave (counter_i, vs_i in; value_o, changed_o,
//          osd_o out, all registered)
module rotary_commit #(
    parameter int W           = 4,
    parameter int INIT        = 0,
    parameter int SETTLE      = 1000,
    parameter int HOLD_FRAMES = 60
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rotary_commit_if.slave      bus
);
    // SETTLE is limited to 2^20-1, so 20 bits always hold the saturated count.
    localparam int             CW       = 20;
    localparam logic [CW-1:0]  SETTLE_C = CW'(SETTLE);
    localparam logic [7:0]     HOLD_C   = 8'(HOLD_FRAMES);
    localparam logic [W-1:0]   INIT_C   = W'(INIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETTLING = 2'd1,
        S_PENDING  = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  cin_q;
    logic [W-1:0]  pend_q;
    logic [W-1:0]  value_q;
    logic          changed_q;
    logic          osd_q;
    logic          vs_q;
    logic [CW-1:0] stab_q;
    logic [CW-1:0] stab_d;
    logic [7:0]    osd_cnt_q;
    logic [7:0]    osd_cnt_d;

    logic          vs_edge_s;
    logic          in_change_s;
    logic          stable_s;
    logic          commit_s;

    assign bus.value_o   = value_q;
    assign bus.changed_o = changed_q;
    assign bus.osd_o     = osd_q;

    // Edge detect, input-change detect and next values of the two counters.
    always_comb begin
        vs_edge_s   = bus.vs_i & ~vs_q;
        in_change_s = (bus.counter_i != cin_q);
        stable_s    = (stab_q == SETTLE_C);
        commit_s    = (state_q == S_PENDING) && vs_edge_s;

        stab_d = stab_q;
        if (in_change_s) begin
            stab_d = {CW{1'b0}};
        end else if (stable_s) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + CW'(1);
        end

        // A commit always reloads (retriggers); otherwise one frame is
        // consumed per vsync edge until the counter reaches zero.
        osd_cnt_d = osd_cnt_q;
        if (commit_s) begin
            osd_cnt_d = HOLD_C;
        end else if (vs_edge_s && (osd_cnt_q != 8'd0)) begin
            osd_cnt_d = osd_cnt_q - 8'd1;
        end else begin
            osd_cnt_d = osd_cnt_q;
        end
    end

    // Commit FSM together with all state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cin_q     <= INIT_C;
            pend_q    <= INIT_C;
            value_q   <= INIT_C;
            changed_q <= 1'b0;
            osd_q     <= 1'b0;
            osd_cnt_q <= 8'd0;
            stab_q    <= {CW{1'b0}};
            // Treat vsync as already high so a level present at reset
            // release is not mistaken for a rising edge.
            vs_q      <= 1'b1;
        end else begin
            cin_q     <= bus.counter_i;
            vs_q      <= bus.vs_i;
            stab_q    <= stab_d;
            osd_cnt_q <= osd_cnt_d;
            osd_q     <= (osd_cnt_d != 8'd0);
            changed_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (in_change_s) begin
                        state_q <= S_SETTLING;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SETTLING: begin
                    if (stable_s) begin
                        if (cin_q != value_q) begin
                            pend_q  <= cin_q;
                            state_q <= S_PENDING;
                        end else begin
                            // Input was moved and returned: nothing to apply.
                            state_q <= S_IDLE;
                        end
                    end else begin
                        state_q <= S_SETTLING;
                    end
                end
                S_PENDING: begin
                    if (vs_edge_s) begin
                        value_q   <= pend_q;
                        changed_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (in_change_s) begin
                        // Input moved again; the next settled value replaces
                        // this one, so the current pend_q is never applied
                        // unless the input settles back on it.
                        state_q <= S_SETTLING;
                    end else begin
                        state_q <= S_PENDING;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rotary_commit.sv
// Testbench for rotary_commit (W=4, INIT=0, SETTLE=4, HOLD_FRAMES=3).
// Stimulus pushes the value each vsync is expected to commit into a queue;
// a monitor pops it whenever changed_o is seen and also flags any value_o
// movement without a strobe or a strobe longer than one cycle.
module tb_rotary_commit;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [3:0] exp_q[$];

    rotary_commit_if #(.W(4)) bus ();

    rotary_commit #(
        .W(4), .INIT(0), .SETTLE(4), .HOLD_FRAMES(3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One vsync pulse: rising edge, then low long enough for the next one.
    task automatic vsync();
        bus.vs_i = 1'b1;
        cyc(2);
        bus.vs_i = 1'b0;
        cyc(2);
    endtask

    task automatic monitor_loop();
        logic [3:0] prev_val;
        logic       prev_chg;
        logic [3:0] e;
        prev_val = 4'd0;
        prev_chg = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_chg = 1'b0;
            end else if (bus.changed_o) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL commit_unexpected: value_o=%0d, expected no commit", bus.value_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.value_o !== e) begin
                        fails++;
                        $display("FAIL commit_value: got %0d, expected %0d", bus.value_o, e);
                    end
                end
                if (prev_chg) begin
                    tests++;
                    fails++;
                    $display("FAIL changed_width: changed_o high 2 cycles, expected 1");
                end
            end else if (bus.value_o !== prev_val) begin
                tests++;
                fails++;
                $display("FAIL value_no_strobe: value_o %0d -> %0d, expected no change", prev_val, bus.value_o);
            end
            prev_val = bus.value_o;
            prev_chg = bus.changed_o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus.vs_i      = 1'b1;
        bus.counter_i = 4'd0;
        fork
            monitor_loop();
        join_none

        // Reset with vsync held high
        cyc(3);
        check("reset_value", bus.value_o, 4'd0);
        check("reset_changed", {3'd0, bus.changed_o}, 4'd0);
        check("reset_osd", {3'd0, bus.osd_o}, 4'd0);
        rst = 1'b0;
        cyc(1);
        check("release_no_commit", {3'd0, bus.changed_o}, 4'd0);
        bus.vs_i = 1'b0;
        cyc(2);

        // 0 -> 5, held, then vsync commits exactly one cycle after the edge
        bus.counter_i = 4'd5;
        cyc(20);
        check("no_commit_before_vs", bus.value_o, 4'd0);
        exp_q.push_back(4'd5);
        bus.vs_i = 1'b1;
        cyc(1);
        check("commit5_changed", {3'd0, bus.changed_o}, 4'd1);
        check("commit5_value", bus.value_o, 4'd5);
        check("commit5_osd", {3'd0, bus.osd_o}, 4'd1);
        cyc(1);
        check("commit5_strobe_end", {3'd0, bus.changed_o}, 4'd0);
        bus.vs_i = 1'b0;
        cyc(2);

        // OSD release after three idle frames
        vsync();
        check("osd_frame1", {3'd0, bus.osd_o}, 4'd1);
        vsync();
        check("osd_frame2", {3'd0, bus.osd_o}, 4'd1);
        vsync();
        check("osd_frame3_off", {3'd0, bus.osd_o}, 4'd0);

        // Short excursion and a turned-and-returned input commit nothing
        bus.counter_i = 4'd7;
        cyc(2);
        bus.counter_i = 4'd5;
        cyc(10);
        vsync();
        vsync();
        check("glitch_no_commit", bus.value_o, 4'd5);
        bus.counter_i = 4'd3;
        cyc(10);
        bus.counter_i = 4'd5;
        cyc(10);
        vsync();
        check("return_no_commit", bus.value_o, 4'd5);

        // Pending 7 superseded by 9 before vsync
        bus.counter_i = 4'd7;
        cyc(10);
        bus.counter_i = 4'd9;
        cyc(10);
        exp_q.push_back(4'd9);
        vsync();
        check("latest_wins", bus.value_o, 4'd9);

        // Toggling every 2 cycles across a vsync never settles
        for (int i = 0; i < 8; i++) begin
            bus.counter_i = (i % 2 == 0) ? 4'd2 : 4'd9;
            if (i == 3) bus.vs_i = 1'b1;
            if (i == 5) bus.vs_i = 1'b0;
            cyc(2);
        end
        cyc(10);
        vsync();
        check("toggle_no_commit", bus.value_o, 4'd9);

        // Retrigger: commit 4, one idle frame, commit 6, then 3 frames of OSD
        bus.counter_i = 4'd4;
        cyc(10);
        exp_q.push_back(4'd4);
        vsync();
        vsync();
        bus.counter_i = 4'd6;
        cyc(10);
        exp_q.push_back(4'd6);
        vsync();
        check("second_commit", bus.value_o, 4'd6);
        vsync();
        check("retrig_frame1", {3'd0, bus.osd_o}, 4'd1);
        vsync();
        check("retrig_frame2", {3'd0, bus.osd_o}, 4'd1);
        vsync();
        check("retrig_frame3_off", {3'd0, bus.osd_o}, 4'd0);

        // Reset while pending discards the pending value and clears OSD
        bus.counter_i = 4'd5;
        cyc(10);
        exp_q.push_back(4'd5);
        vsync();
        check("pre_reset_value", bus.value_o, 4'd5);
        bus.counter_i = 4'd8;
        cyc(10);
        check("pre_reset_osd", {3'd0, bus.osd_o}, 4'd1);
        rst = 1'b1;
        bus.counter_i = 4'd0;
        cyc(1);
        check("midreset_value", bus.value_o, 4'd0);
        check("midreset_osd", {3'd0, bus.osd_o}, 4'd0);
        cyc(1);
        rst = 1'b0;
        cyc(10);
        vsync();
        check("post_reset_no_commit", bus.value_o, 4'd0);
        check("post_reset_osd", {3'd0, bus.osd_o}, 4'd0);

        cyc(4);
        check("all_commits_seen", 4'(exp_q.size()), 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
